// File: rtl/bp_link_concentrator_pkg.sv
// Shared types and id helpers for the N:1 link concentrator.
package bp_link_concentrator_pkg;

    localparam int DROP_W = 8;

    typedef enum logic {FWD_IDLE, FWD_HOLD} fwd_state_e;

    function automatic int chan_to_id(int chan, int base);
        return base + chan;
    endfunction

    // Signed result so ids below the base come out negative.
    function automatic int id_to_chan(int id, int base);
        return id - base;
    endfunction

endpackage

// File: rtl/bp_link_fifo.sv
// Per-channel ready-and FIFO; ready only reflects fullness, never the same-cycle valid.
module bp_link_fifo
    import bp_link_concentrator_pkg::*;
#(
    parameter int DATA_W     = 64,
    parameter int FIFO_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enq_v,
    input  logic [DATA_W-1:0] enq_data,
    output logic              enq_ready,
    input  logic              deq,
    output logic [DATA_W-1:0] deq_data,
    output logic              deq_v
);
    localparam int AW = $clog2(FIFO_DEPTH);

    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]     rd_ptr, wr_ptr;
    logic [AW:0]       count;
    logic              enq;

    assign enq       = enq_v & enq_ready;
    assign enq_ready = (count != (AW+1)'(FIFO_DEPTH));
    assign deq_v     = (count != '0);
    assign deq_data  = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (enq) wr_ptr <= wr_ptr + 1'b1;
            if (deq) rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(enq) - (AW+1)'(deq);
        end
    end

    // Storage needs no reset: the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (enq) mem[wr_ptr] <= enq_data;
    end

endmodule

// File: rtl/bp_link_concentrator.sv
// N:1 ready-and concentrator (forward, id-tagged, arbitrated) and 1:N splitter (reverse, by id).
module bp_link_concentrator
    import bp_link_concentrator_pkg::*;
#(
    parameter int NUM_CHAN   = 2,
    parameter int DATA_W     = 64,
    parameter int CHAN_BASE  = 1,
    parameter int ID_W       = 4,
    parameter int FIFO_DEPTH = 2,
    parameter int FIXED_PRIO = 0
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic [NUM_CHAN-1:0]        fwd_v_i,
    input  logic [NUM_CHAN*DATA_W-1:0] fwd_data_i,
    output logic [NUM_CHAN-1:0]        fwd_ready_and_o,
    output logic                       mesh_v_o,
    output logic [ID_W+DATA_W-1:0]     mesh_data_o,
    input  logic                       mesh_ready_and_i,
    input  logic                       mesh_v_i,
    input  logic [ID_W+DATA_W-1:0]     mesh_data_i,
    output logic                       mesh_ready_and_o,
    output logic [NUM_CHAN-1:0]        rev_v_o,
    output logic [NUM_CHAN*DATA_W-1:0] rev_data_o,
    input  logic [NUM_CHAN-1:0]        rev_ready_and_i,
    output logic                       bad_id_o,
    output logic [DROP_W-1:0]          drop_cnt_o
);
    localparam int CW = (NUM_CHAN > 1) ? $clog2(NUM_CHAN) : 1;

    typedef struct packed {
        logic [ID_W-1:0]   id;
        logic [DATA_W-1:0] data;
    } flit_t;

    logic [NUM_CHAN-1:0]             q_v, q_pop;
    logic [NUM_CHAN-1:0][DATA_W-1:0] q_data;

    for (genvar k = 0; k < NUM_CHAN; k++) begin : g_fifo
        bp_link_fifo #(.DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
            .clk      (clk_i),
            .rst      (reset_i),
            .enq_v    (fwd_v_i[k]),
            .enq_data (fwd_data_i[k*DATA_W +: DATA_W]),
            .enq_ready(fwd_ready_and_o[k]),
            .deq      (q_pop[k]),
            .deq_data (q_data[k]),
            .deq_v    (q_v[k])
        );
    end

    fwd_state_e    state;
    flit_t         out_flit;
    logic [CW-1:0] rr_ptr;   // next index to search from
    logic [CW-1:0] gnt;
    logic          gnt_v, load;

    function automatic int rot(int i, logic [CW-1:0] ptr);
        return (FIXED_PRIO != 0) ? i : (int'(ptr) + i) % NUM_CHAN;
    endfunction

    // Walk from lowest to highest priority so the highest-priority hit is written last.
    always_comb begin
        gnt_v = 1'b0;
        gnt   = '0;
        for (int i = NUM_CHAN - 1; i >= 0; i--) begin
            if (q_v[rot(i, rr_ptr)]) begin
                gnt_v = 1'b1;
                gnt   = CW'(rot(i, rr_ptr));
            end
        end
    end

    assign load        = gnt_v & ((state == FWD_IDLE) | mesh_ready_and_i);
    assign q_pop       = load ? (NUM_CHAN'(1) << gnt) : '0;
    assign mesh_v_o    = (state == FWD_HOLD);
    assign mesh_data_o = out_flit;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state    <= FWD_IDLE;
            out_flit <= '0;
            rr_ptr   <= '0;
        end else if (load) begin
            state         <= FWD_HOLD;
            out_flit.id   <= ID_W'(chan_to_id(int'(gnt), CHAN_BASE));
            out_flit.data <= q_data[gnt];
            rr_ptr        <= (int'(gnt) == NUM_CHAN - 1) ? '0 : gnt + 1'b1;
        end else if (state == FWD_HOLD && mesh_ready_and_i) begin
            state <= FWD_IDLE;
        end
    end

    int                              rev_chan;
    logic                            rev_ok, rev_acc;
    logic [NUM_CHAN-1:0]             rev_hit;
    logic [NUM_CHAN-1:0][DATA_W-1:0] rev_q;

    always_comb begin
        rev_chan = id_to_chan(int'(mesh_data_i[ID_W+DATA_W-1 -: ID_W]), CHAN_BASE);
        rev_ok   = (rev_chan >= 0) && (rev_chan < NUM_CHAN);
        rev_hit  = '0;
        for (int k = 0; k < NUM_CHAN; k++) rev_hit[k] = rev_ok && (rev_chan == k);
    end

    // Out-of-range ids are always accepted so a bad flit can never wedge the port.
    assign mesh_ready_and_o = !rev_ok | (|(rev_hit & (~rev_v_o | rev_ready_and_i)));
    assign rev_acc          = mesh_v_i & mesh_ready_and_o;
    assign rev_data_o       = rev_q;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            rev_v_o    <= '0;
            rev_q      <= '0;
            bad_id_o   <= 1'b0;
            drop_cnt_o <= '0;
        end else begin
            for (int k = 0; k < NUM_CHAN; k++) begin
                if (rev_acc && rev_hit[k]) begin
                    rev_v_o[k] <= 1'b1;
                    rev_q[k]   <= mesh_data_i[DATA_W-1:0];
                end else if (rev_ready_and_i[k]) begin
                    rev_v_o[k] <= 1'b0;
                end
            end
            if (rev_acc && !rev_ok) begin
                bad_id_o <= 1'b1;
                if (drop_cnt_o != '1) drop_cnt_o <= drop_cnt_o + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_bp_link_concentrator.sv
// Randomized + directed bench against a queue-based reference model of the concentrator.
module tb_bp_link_concentrator;
    localparam int N = 4, DW = 64, BASE = 1, IW = 4, DEPTH = 2;

    logic clk = 1'b0;
    logic rst;
    logic [N-1:0]    fwd_v, fwd_rdy, fwd_rdy2, rev_v, rev_v2, rev_rdy;
    logic [N*DW-1:0] fwd_data, rev_d, rev_d2;
    logic            mesh_v, mesh_v2, mesh_rdy_in, mv_in, mrdy_out, mrdy_out2, bad, bad2;
    logic [IW+DW-1:0] mesh_d, mesh_d2, md_in;
    logic [7:0]      drops, drops2;

    always #5 clk = ~clk;

    bp_link_concentrator #(.NUM_CHAN(N), .DATA_W(DW), .CHAN_BASE(BASE), .ID_W(IW),
                           .FIFO_DEPTH(DEPTH), .FIXED_PRIO(0)) dut (
        .clk_i(clk), .reset_i(rst), .fwd_v_i(fwd_v), .fwd_data_i(fwd_data),
        .fwd_ready_and_o(fwd_rdy), .mesh_v_o(mesh_v), .mesh_data_o(mesh_d),
        .mesh_ready_and_i(mesh_rdy_in), .mesh_v_i(mv_in), .mesh_data_i(md_in),
        .mesh_ready_and_o(mrdy_out), .rev_v_o(rev_v), .rev_data_o(rev_d),
        .rev_ready_and_i(rev_rdy), .bad_id_o(bad), .drop_cnt_o(drops));

    bp_link_concentrator #(.NUM_CHAN(N), .DATA_W(DW), .CHAN_BASE(BASE), .ID_W(IW),
                           .FIFO_DEPTH(DEPTH), .FIXED_PRIO(1)) dut_fp (
        .clk_i(clk), .reset_i(rst), .fwd_v_i(fwd_v), .fwd_data_i(fwd_data),
        .fwd_ready_and_o(fwd_rdy2), .mesh_v_o(mesh_v2), .mesh_data_o(mesh_d2),
        .mesh_ready_and_i(mesh_rdy_in), .mesh_v_i(mv_in), .mesh_data_i(md_in),
        .mesh_ready_and_o(mrdy_out2), .rev_v_o(rev_v2), .rev_data_o(rev_d2),
        .rev_ready_and_i(rev_rdy), .bad_id_o(bad2), .drop_cnt_o(drops2));

    int errors = 0, checks = 0;

    task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Reference model state
    logic [DW-1:0]    fq [N][$];
    bit               hold_v;
    logic [IW+DW-1:0] hold_f;
    int               start;
    bit               m_rev_v [N];
    logic [DW-1:0]    m_rev_d [N];
    bit               m_bad;
    int               m_drops;

    task automatic m_reset();
        for (int k = 0; k < N; k++) begin
            fq[k].delete();
            m_rev_v[k] = 0;
            m_rev_d[k] = '0;
        end
        hold_v = 0; start = 0; m_bad = 0; m_drops = 0;
    endtask

    function automatic bit m_mrdy(logic [IW+DW-1:0] d, logic [N-1:0] rr);
        int c = int'(d[IW+DW-1:DW]) - BASE;
        if (c < 0 || c >= N) return 1'b1;
        return !m_rev_v[c] || rr[c];
    endfunction

    function automatic logic [IW+DW-1:0] flit(int id, logic [DW-1:0] p);
        return {IW'(id), p};
    endfunction

    function automatic logic [N*DW-1:0] rnd_fd();
        logic [N*DW-1:0] fd;
        for (int k = 0; k < N; k++) fd[k*DW +: DW] = {$urandom(), $urandom()};
        return fd;
    endfunction

    // One clock: drive at negedge, compare against model, advance model, move to next negedge.
    task automatic cycle(input logic [N-1:0] fv, input logic [N*DW-1:0] fd, input bit mr,
                         input bit mv, input logic [IW+DW-1:0] md, input logic [N-1:0] rr);
        bit acc [N];
        bit rdy;
        int g, c;
        logic [DW-1:0] d;
        fwd_v = fv; fwd_data = fd; mesh_rdy_in = mr; mv_in = mv; md_in = md; rev_rdy = rr;
        #1;
        for (int k = 0; k < N; k++) chk("fwd_ready", fwd_rdy[k], fq[k].size() < DEPTH);
        chk("mesh_v", mesh_v, hold_v);
        if (hold_v) chk("mesh_data", mesh_d, hold_f);
        rdy = m_mrdy(md, rr);
        chk("mesh_ready_out", mrdy_out, rdy);
        for (int k = 0; k < N; k++) begin
            chk("rev_v", rev_v[k], m_rev_v[k]);
            if (m_rev_v[k]) chk("rev_data", rev_d[k*DW +: DW], m_rev_d[k]);
        end
        chk("bad_id", bad, m_bad);
        chk("drop_cnt", drops, m_drops);

        for (int k = 0; k < N; k++) acc[k] = fv[k] && fq[k].size() < DEPTH;
        g = -1;
        if (!hold_v || mr)
            for (int i = 0; i < N; i++) begin
                int j = (start + i) % N;
                if (g < 0 && fq[j].size() > 0) g = j;
            end
        if (g >= 0) begin
            d = fq[g].pop_front();
            hold_f = {IW'(BASE + g), d};
            hold_v = 1;
            start = (g + 1) % N;
        end else if (hold_v && mr) hold_v = 0;
        for (int k = 0; k < N; k++) if (acc[k]) fq[k].push_back(fd[k*DW +: DW]);

        c = int'(md[IW+DW-1:DW]) - BASE;
        for (int k = 0; k < N; k++) if (m_rev_v[k] && rr[k]) m_rev_v[k] = 0;
        if (mv && rdy) begin
            if (c >= 0 && c < N) begin
                m_rev_v[c] = 1;
                m_rev_d[c] = md[DW-1:0];
            end else begin
                m_bad = 1;
                if (m_drops < 255) m_drops++;
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        fwd_v = '0; mv_in = 0; mesh_rdy_in = 0; md_in = '0; rev_rdy = '0; fwd_data = '0;
        rst = 1;
        @(negedge clk);
        rst = 0;
        m_reset();
    endtask

    logic [N*DW-1:0] fd;

    initial begin
        rst = 1; fwd_v = '0; fwd_data = '0; mesh_rdy_in = 0; mv_in = 0; md_in = '0; rev_rdy = '0;
        m_reset();
        @(negedge clk); @(negedge clk);
        chk("reset_fwd_ready", fwd_rdy, 4'hF);
        chk("reset_mesh_v", mesh_v, 0);
        chk("reset_rev_v", rev_v, 0);
        chk("reset_mesh_ready", mrdy_out, 1);
        chk("reset_bad", bad, 0);
        chk("reset_drops", drops, 0);
        rst = 0;
        @(negedge clk);

        // Single flit on channel 1 appears two edges later tagged with id 2
        fd = '0; fd[DW +: DW] = 64'hA5;
        cycle(4'b0010, fd, 1, 0, '0, '0);
        cycle(4'b0000, '0, 1, 0, '0, '0);
        #1;
        chk("single_v", mesh_v, 1);
        chk("single_data", mesh_d, {4'd2, 64'hA5});
        cycle(4'b0000, '0, 1, 0, '0, '0);

        // All channels streaming: round-robin ids; fixed-priority twin only ever sends id 1
        do_reset();
        for (int i = 0; i < 16; i++) begin
            cycle('1, rnd_fd(), 1, 0, '0, '0);
            if (i >= 2) chk("fixed_prio_v", mesh_v2, 1);
            if (mesh_v2) chk("fixed_prio_id", mesh_d2[IW+DW-1:DW], 1);
        end

        // Backpressure: three flits on channel 0 against a stalled mesh
        do_reset();
        for (int i = 0; i < 3; i++) cycle(4'b0001, rnd_fd(), 0, 0, '0, '0);
        for (int i = 0; i < 7; i++) cycle(4'b0000, '0, 0, 0, '0, '0);
        #1 chk("bp_full", fwd_rdy[0], 0);
        for (int i = 0; i < 5; i++) cycle(4'b0000, '0, 1, 0, '0, '0);

        // Reverse demux and per-channel blocking
        do_reset();
        cycle('0, '0, 1, 1, flit(2, 64'h55), 4'b0000);
        cycle('0, '0, 1, 1, flit(1, 64'h66), 4'b0000);
        #1 chk("rev_both_v", rev_v, 4'b0011);
        chk("rev_ch1_data", rev_d[DW +: DW], 64'h55);
        chk("rev_blocked", mrdy_out, 0);
        cycle('0, '0, 1, 1, flit(2, 64'h77), 4'b0000);
        cycle('0, '0, 1, 1, flit(2, 64'h77), 4'b0010);
        cycle('0, '0, 1, 0, '0, 4'b1111);
        cycle('0, '0, 1, 0, '0, 4'b1111);

        // Out-of-range ids are dropped and counted, saturating
        do_reset();
        cycle('0, '0, 1, 1, flit(0, 64'h1), '0);
        cycle('0, '0, 1, 1, flit(5, 64'h2), '0);
        #1 chk("bad_two", drops, 2);
        chk("bad_flag", bad, 1);
        chk("bad_no_rev", rev_v, 0);
        for (int i = 0; i < 298; i++)
            cycle('0, '0, 1, 1, flit(($urandom_range(0, 1) != 0) ? 0 : int'($urandom_range(5, 15)),
                  {$urandom(), $urandom()}), '0);
        #1 chk("drop_sat", drops, 255);

        // Random traffic in both directions
        do_reset();
        for (int i = 0; i < 2000; i++)
            cycle(N'($urandom()), rnd_fd(), $urandom_range(0, 3) != 0, $urandom_range(0, 1) != 0,
                  flit(int'($urandom_range(0, 6)), {$urandom(), $urandom()}), N'($urandom()));

        // Asynchronous reset with HOLD stalled, FIFOs full and reverse state live
        for (int i = 0; i < 4; i++) cycle('1, rnd_fd(), 0, 1, flit(0, 64'h9), 4'b0000);
        cycle('0, '0, 0, 1, flit(3, 64'h33), 4'b0000);
        #2 rst = 1;
        #1;
        chk("async_fwd_ready", fwd_rdy, 4'hF);
        chk("async_mesh_v", mesh_v, 0);
        chk("async_rev_v", rev_v, 0);
        chk("async_bad", bad, 0);
        chk("async_drops", drops, 0);
        fwd_v = '0; mv_in = 0; mesh_rdy_in = 0; md_in = '0;
        @(negedge clk);
        rst = 0;
        m_reset();
        fd = '0; fd[2*DW +: DW] = 64'hBEEF;
        cycle(4'b0100, fd, 1, 0, '0, '0);
        cycle(4'b0000, '0, 1, 0, '0, '0);
        #1 chk("post_reset_data", mesh_d, {4'd3, 64'hBEEF});
        cycle(4'b0000, '0, 1, 0, '0, '0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bp_link_concentrator.md
Name: bp_link_concentrator

Overview:
- Parametrised N:1 concentrator/splitter for ready-and links, successor to the fixed two-entry io mesh hookup.
- Forward direction: N source links buffered per channel, round-robin arbitrated onto one mesh link, each flit tagged with its absolute channel id.
- Reverse direction: one mesh link demultiplexed back to N links by channel id carried in the flit.
- Channel ids start at CHAN_BASE, not necessarily 0.

Parameters:
- NUM_CHAN, 2, number of channel links (1..16)
- DATA_W, 64, payload width per flit
- CHAN_BASE, 1, absolute id of channel 0
- ID_W, 4, channel-id field width; must hold CHAN_BASE+NUM_CHAN-1
- FIFO_DEPTH, 2, per-channel forward buffer depth (power of 2, >=2)
- FIXED_PRIO, 0, 1 = fixed priority (lowest index wins) instead of round-robin

Ports:
- clk_i  in  1  clock
- reset_i  in  1  reset, asynchronous, active-high
- fwd_v_i  in  NUM_CHAN  per-channel forward valid
- fwd_data_i  in  NUM_CHAN*DATA_W  forward payloads, channel k at [k*DATA_W +: DATA_W]
- fwd_ready_and_o  out  NUM_CHAN  per-channel forward ready
- mesh_v_o  out  1  concentrated valid
- mesh_data_o  out  ID_W+DATA_W  {channel id, payload}
- mesh_ready_and_i  in  1  mesh ready
- mesh_v_i  in  1  reverse valid
- mesh_data_i  in  ID_W+DATA_W  {dest id, payload}
- mesh_ready_and_o  out  1  reverse ready
- rev_v_o  out  NUM_CHAN  per-channel reverse valid
- rev_data_o  out  NUM_CHAN*DATA_W  reverse payloads
- rev_ready_and_i  in  NUM_CHAN  per-channel reverse ready
- bad_id_o  out  1  sticky: reverse flit with out-of-range id dropped
- drop_cnt_o  out  8  count of dropped reverse flits, saturating at 255

Behaviour:
- Handshake: transfer when v & ready_and in the same cycle. Ready never depends on same-port valid.
- Reset, asynchronous: all FIFOs empty, fwd_ready_and_o all 1, mesh_v_o=0, rev_v_o=0, mesh_ready_and_o=1, RR pointer=0, bad_id_o=0, drop_cnt_o=0, output registers cleared.
- Forward FIFOs:
  - fwd_ready_and_o[k] = !full[k].
  - Simultaneous enqueue and dequeue when full is not permitted, since ready is deasserted.
  - Simultaneous enqueue and dequeue when non-empty keeps the count unchanged.
- Forward output stage: one-entry register, IDLE/HOLD.
  - IDLE: if any FIFO is non-empty, the arbiter grants one, pops it, loads {CHAN_BASE+k, data}, and moves to HOLD.
  - HOLD: mesh_v_o=1 and data is held stable. On mesh_ready_and_i, either load the next grant in the same cycle (stay HOLD, full throughput) or go to IDLE.
  - Minimum latency from fwd accept to mesh_v_o is 2 cycles.
- Arbiter:
  - Round-robin: search starts at the index after the last grant and wraps NUM_CHAN-1 -> 0. The pointer updates only on grant.
  - FIXED_PRIO=1: index 0 always wins.
  - No grant while HOLD is stalled.
- Reverse path, one-entry register per channel:
  - idx = mesh_data_i id - CHAN_BASE, computed at ID_W+1 bits so underflow is detectable.
  - mesh_ready_and_o = !rev_v_o[idx] | rev_ready_and_i[idx] for a valid idx; 1 for an invalid idx.
  - Accepted valid idx: load rev register idx. rev_v_o[idx] is set the next cycle and cleared on rev_ready_and_i.
  - Out-of-range id (below CHAN_BASE or >= CHAN_BASE+NUM_CHAN): accept and drop, set bad_id_o, increment drop_cnt_o with saturation. bad_id_o clears only on reset.
  - Reverse flits to different channels flow without head-of-line blocking except on the single accept port.
- Reset asserted mid-transfer discards all buffered flits; no partial state survives.
- NUM_CHAN=1: arbiter degenerates to pass-through; ids are still tagged.

Decomposition:
- Package bp_link_concentrator_pkg:
  - flit typedef, packed {id, data}
  - function chan_to_id / id_to_chan
  - drop-count width constant
- Sub-module bp_link_fifo: per-channel ready-and FIFO, parametrised DATA_W and FIFO_DEPTH, instantiated NUM_CHAN times in a generate loop.
- Arbiter stays inline.

Test Plan:
- Single flit: NUM_CHAN=2, CHAN_BASE=1, ch1 sends 64'hA5, mesh ready -> mesh_v_o rises 2 cycles later with mesh_data_o={4'd2,64'hA5}; fwd_ready_and_o stays 1.
- Round-robin fairness: all 4 channels continuously valid (NUM_CHAN=4), mesh always ready -> ids 1,2,3,4,1,2,... one flit per cycle; FIXED_PRIO=1 -> only id 1 streams.
- Backpressure: mesh_ready_and_i=0 for 10 cycles while ch0 pushes 3 flits, FIFO_DEPTH=2 -> 1 flit in HOLD, 2 buffered, fwd_ready_and_o[0]=0; release -> order preserved, no loss.
- Reverse demux: id 2 payload 64'h55 with rev_ready_and_i[1]=0 -> rev_v_o[1]=1 held; a following id 1 flit is accepted onto rev_v_o[0] the next cycle; a second id 2 flit sees mesh_ready_and_o=0 until channel 1 drains.
- Bad id: ids 0 and 5 with CHAN_BASE=1, NUM_CHAN=4 -> both accepted, no rev_v_o, bad_id_o=1, drop_cnt_o=2; 300 bad flits -> drop_cnt_o=255.
- Mid-operation reset: assert reset_i asynchronously while HOLD and FIFOs are full -> all outputs return to reset values immediately; the first post-reset flit is delivered normally.
